// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper: sequences N up/down phase steps on the Cyclone III PLL dynamic phase-shift port,
// generating scanclk/phasestep and waiting on a synchronized phasedone handshake between steps.
module pll_phase_stepper #(
    parameter int SCAN_HALF    = 16,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_start,
    input  logic [2:0] req_counter,
    input  logic       req_updown,
    input  logic [7:0] req_nsteps,
    input  logic       phasedone,
    output logic       busy,
    output logic       done,
    output logic [7:0] step_count,
    output logic       timeout_err,
    output logic [2:0] phasecounterselect,
    output logic       phaseupdown,
    output logic       phasestep,
    output logic       scanclk
);
    localparam int HW = (SCAN_HALF > 2) ? $clog2(SCAN_HALF) : 1;
    localparam int RW = $clog2(DONE_TIMEOUT + 3);

    typedef enum logic [2:0] {IDLE, SETUP, ASSERT, WAIT_DONE, FINISH} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          sclk_q, sclk_d, ps_q, ps_d, ud_q, ud_d;
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    nsteps_q, nsteps_d, cnt_q, cnt_d, cnt_inc;
    logic          terr_q, terr_d, done_q, done_d, zero_q, zero_d;
    logic          seen_q, seen_d, pend_q, pend_d;
    logic          pd_m_q, pd_s_q;
    logic          tick, rise, fall;

    always_comb begin
        tick     = (state_q != IDLE) && (hcnt_q == HW'(SCAN_HALF - 1));
        rise     = tick && !sclk_q;
        fall     = tick && sclk_q;
        cnt_inc  = cnt_q + 8'd1;
        state_d  = state_q;
        hcnt_d   = (state_q == IDLE || tick) ? '0 : hcnt_q + HW'(1);
        sclk_d   = (state_q == IDLE) ? 1'b0 : sclk_q ^ tick;
        rcnt_d   = rcnt_q;
        ps_d     = ps_q;
        ud_d     = ud_q;
        sel_d    = sel_q;
        nsteps_d = nsteps_q;
        cnt_d    = cnt_q;
        terr_d   = terr_q;
        done_d   = zero_q;
        zero_d   = 1'b0;
        seen_d   = seen_q;
        pend_d   = pend_q;
        case (state_q)
            IDLE: begin
                ps_d = 1'b0;
                if (req_start) begin
                    cnt_d  = '0;
                    terr_d = 1'b0;
                    if (req_nsteps == 8'd0) begin
                        zero_d = 1'b1;
                    end else begin
                        sel_d    = req_counter;
                        ud_d     = req_updown;
                        nsteps_d = req_nsteps;
                        pend_d   = 1'b0;
                        rcnt_d   = '0;
                        state_d  = SETUP;
                    end
                end
            end
            SETUP: if (fall) begin
                ps_d    = 1'b1;
                seen_d  = 1'b0;
                rcnt_d  = '0;
                state_d = ASSERT;
            end
            ASSERT: begin
                if (!pd_s_q) seen_d = 1'b1;
                if (rise) rcnt_d = rcnt_q + RW'(1);
                if (fall && rcnt_q == RW'(2)) begin
                    ps_d    = 1'b0;
                    rcnt_d  = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!pd_s_q) seen_d = 1'b1;
                // a completed step re-arms phasestep only on the following scanclk fall
                if (pend_q) begin
                    if (fall) begin
                        ps_d    = 1'b1;
                        seen_d  = 1'b0;
                        pend_d  = 1'b0;
                        rcnt_d  = '0;
                        state_d = ASSERT;
                    end
                end else if (seen_q && pd_s_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == nsteps_q) state_d = FINISH;
                    else pend_d = 1'b1;
                end else if (rise) begin
                    rcnt_d = rcnt_q + RW'(1);
                    if (rcnt_q == RW'(DONE_TIMEOUT - 1)) begin
                        terr_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: if (!sclk_q) begin
                done_d  = 1'b1;
                sclk_d  = 1'b0;
                hcnt_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            rcnt_q   <= '0;
            sclk_q   <= 1'b0;
            ps_q     <= 1'b0;
            ud_q     <= 1'b1;
            sel_q    <= 3'b000;
            nsteps_q <= '0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            seen_q   <= 1'b0;
            pend_q   <= 1'b0;
            pd_m_q   <= 1'b1;
            pd_s_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            rcnt_q   <= rcnt_d;
            sclk_q   <= sclk_d;
            ps_q     <= ps_d;
            ud_q     <= ud_d;
            sel_q    <= sel_d;
            nsteps_q <= nsteps_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            seen_q   <= seen_d;
            pend_q   <= pend_d;
            pd_m_q   <= phasedone;
            pd_s_q   <= pd_m_q;
        end
    end

    assign busy               = (state_q != IDLE);
    assign done               = done_q;
    assign step_count         = cnt_q;
    assign timeout_err        = terr_q;
    assign phasecounterselect = sel_q;
    assign phaseupdown        = ud_q;
    assign phasestep          = ps_q;
    assign scanclk            = sclk_q;
endmodule

// File: doc/pll_phase_stepper.md
# pll_phase_stepper

Sequencer for the Cyclone III PLL dynamic phase-shift port. It accepts a "step counter N times up/down" request from the serial command processor and generates the phasecounterselect/phaseupdown/phasestep/scanclk waveform for each step. It waits for the PLL's phasedone handshake between steps, and reports completion, step count and timeout. It replaces ad-hoc scanclk toggling in the command FSM so that multi-step and per-counter shifts are sequenced in one place.

## Interface
Parameters:
- SCAN_HALF, 16: clk cycles per scanclk half-period (≥2).
- DONE_TIMEOUT, 16: scanclk rising edges allowed in WAIT_DONE before abort.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_start  in  1  one-cycle request strobe; ignored while busy=1.
- req_counter  in  3  counter select (000 all, 001 M, 010 C0 … 110 C4), sampled on req_start.
- req_updown  in  1  1=up, 0=down, sampled on req_start.
- req_nsteps  in  8  number of phase steps, sampled on req_start.
- phasedone  in  1  PLL phasedone (async, low while a shift is in progress).
- busy  out  1  high from accept to FINISH.
- done  out  1  one-cycle pulse at end of a request (including nsteps=0 and timeout).
- step_count  out  8  steps completed in current/last request.
- timeout_err  out  1  sticky; set on timeout, cleared on next accepted req_start.
- phasecounterselect  out  3  to PLL.
- phaseupdown  out  1  to PLL.
- phasestep  out  1  to PLL.
- scanclk  out  1  to PLL.

## Operation
- Reset values: busy=0, done=0, step_count=0, timeout_err=0, phasecounterselect=000, phaseupdown=1, phasestep=0, scanclk=0, state IDLE, synchronizer flops=1.
- phasedone passes through a 2-flop synchronizer (pd_s). All handshake checks use pd_s.
- Half-period counter hcnt (runs only when busy): increments each clk. At hcnt==SCAN_HALF-1 it toggles scanclk and sets hcnt=0. A toggle 0→1 is a "rise"; 1→0 is a "fall".
- IDLE: scanclk=0, phasestep=0, hcnt=0.
  - req_start with req_nsteps≠0: latch counter, updown and nsteps, drive them onto phasecounterselect/phaseupdown, clear step_count and timeout_err, set busy=1, go to SETUP.
  - req_start with req_nsteps=0: clear step_count and timeout_err, pulse done the next cycle, stay in IDLE. busy stays 0.
- SETUP: one full scanclk period with phasestep=0, so select/updown are registered by the PLL. At the first fall, set phasestep=1, clear seen_low, go to ASSERT.
- ASSERT: phasestep held high across two rises. pd_s=0 at any time sets seen_low. At the fall after the 2nd rise, set phasestep=0, clear the rise counter, go to WAIT_DONE.
- WAIT_DONE: scanclk keeps running. pd_s=0 sets seen_low.
  - seen_low=1 and pd_s=1: step_count+1. If the new count equals nsteps, go to FINISH. Otherwise wait for the next fall, then set phasestep=1, clear seen_low, go to ASSERT.
  - DONE_TIMEOUT rises counted in WAIT_DONE without completion: set timeout_err=1, go to FINISH. step_count is not incremented.
- FINISH: if scanclk=1, keep counting until the next fall. With scanclk=0, pulse done for 1 cycle, set busy=0, go to IDLE. phasecounterselect/phaseupdown hold their last values.
- step_count is 8-bit and never exceeds nsteps, so it cannot wrap.
- req_start while busy is dropped; latched parameters are unchanged.
- rst during any state aborts immediately to reset values; the PLL may be left mid-shift.

## Timing
- Request accepted on the clk edge where req_start=1. busy=1 from the next cycle.
- With H=SCAN_HALF, taking the accept edge as t=0:
  - scanclk rises at H and falls at 2H.
  - phasestep=1 from 2H.
  - Rises at 3H and 5H; phasestep=0 from 6H, so phasestep is high for 4H clk = 2 scanclk periods.
- Subsequent steps: phasestep re-asserts on the first fall after completion is detected.
- Completion detect latency: 2 clk (synchronizer) + 1 clk after phasedone rises.
- nsteps=0: done at t=1, no scanclk activity.
- done and busy→0 occur on the same cycle. A new req_start is accepted the cycle after done.

## Test plan
- Single step, H=16, counter=011, up. PLL model drives phasedone low 1 scanclk after the 2nd rise and high 2 scanclk later. Expect phasestep high t=32..95, one step, step_count=1, done once, timeout_err=0, scanclk=0 at end.
- 3 steps, counter=000, down. Expect phaseupdown=0 throughout, exactly 3 phasestep pulses each 4H long, step_count=3, single done pulse.
- nsteps=0. Expect done at t=1, busy never high, scanclk/phasestep stay 0.
- phasedone stuck high, nsteps=2. Expect timeout_err=1 after 16 rises in WAIT_DONE, step_count=0, done pulse, busy=0. The next req_start clears timeout_err.
- req_start (nsteps=5) pulsed mid-request of nsteps=2. Expect it ignored, final step_count=2.
- rst asserted while phasestep=1. Expect all outputs at reset values immediately (async), and a clean request after release.
